// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals around the ALU arbiter.
interface alu_arbiter_if #(
  parameter int unsigned BITWIDTH      = 32,
  parameter int unsigned OPERATORWIDTH = 5
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [OPERATORWIDTH-1:0] req0_op;
  logic [BITWIDTH-1:0]      req0_a;
  logic [BITWIDTH-1:0]      req0_b;

  logic                     req1_valid;
  logic                     req1_ready;
  logic [OPERATORWIDTH-1:0] req1_op;
  logic [BITWIDTH-1:0]      req1_a;
  logic [BITWIDTH-1:0]      req1_b;

  logic [OPERATORWIDTH-1:0] alu_op;
  logic [BITWIDTH-1:0]      alu_a;
  logic [BITWIDTH-1:0]      alu_b;
  logic [BITWIDTH-1:0]      alu_result;
  logic                     alu_flag;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_id;
  logic [BITWIDTH-1:0]      rsp_result;
  logic                     rsp_flag;
  logic                     rsp_err;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result, alu_flag,
    output rsp_valid, rsp_id, rsp_result, rsp_flag, rsp_err,
    input  rsp_ready
  );

  // Requester / ALU / consumer side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result, alu_flag,
    input  rsp_valid, rsp_id, rsp_result, rsp_flag, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered into the ALU, the result is registered into a held,
// id-tagged response.
module alu_arbiter #(
  parameter int unsigned BITWIDTH      = 32,
  parameter int unsigned OPERATORWIDTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   cur_id;
  logic   can_accept;
  logic   win;
  logic   accept;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b00101, 5'b01101, 5'b00110, 5'b00111, 5'b11000, 5'b11001,
      5'b11100, 5'b11101, 5'b11110, 5'b11111: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, grant and ready; ready never depends on ALU outputs
  always_comb begin
    state_nxt      = state;
    can_accept     = 1'b0;
    win            = 1'b0;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;

    can_accept = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    win        = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    accept     = can_accept && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = can_accept && bus.req0_valid && !win;
    bus.req1_ready = can_accept && bus.req1_valid && win;

    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, response capture in EXEC, release on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant     <= 1'b1;
      cur_id         <= 1'b0;
      bus.alu_op     <= OPERATORWIDTH'(0);
      bus.alu_a      <= BITWIDTH'(0);
      bus.alu_b      <= BITWIDTH'(0);
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= BITWIDTH'(0);
      bus.rsp_flag   <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        bus.alu_op <= win ? bus.req1_op : bus.req0_op;
        bus.alu_a  <= win ? bus.req1_a  : bus.req0_a;
        bus.alu_b  <= win ? bus.req1_b  : bus.req0_b;
        cur_id     <= win;
        last_grant <= win;
      end
      if (state == EXEC) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id    <= cur_id;
        if (op_legal(bus.alu_op)) begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_flag   <= bus.alu_flag;
          bus.rsp_err    <= 1'b0;
        end else begin
          bus.rsp_result <= BITWIDTH'(0);
          bus.rsp_flag   <= 1'b0;
          bus.rsp_err    <= 1'b1;
        end
      end else if ((state == RESP) && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

endmodule
